axis_tx_frame: RTL and testbench

Synthesizable AXI-Stream transmitter that serializes a parallel N-character result frame from the core onto the `M_AXIS_*` output stream. It terminates each frame with TLAST. It sits between the forward/argmax stage of the train/forward datapath and the DMA-facing output port. It is the producing end of the stream that host-side receivers and `recieve_data`-style bench tasks consume.

---
 rtl/axis_tx_frame.sv | 154 +++++++++++++++
 tb/tb_axis_tx_frame.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_tx_frame.sv
// AXI-Stream frame transmitter: buffers parallel N-character frames and streams them
// one character per beat, marking the final character with TLAST. Define AXIS_TX_DBUF_EN for two frame slots.
module axis_tx_frame #(
  parameter int N        = 10,
  parameter int CHAR_LEN = 8,
  parameter int CNT_W    = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  load,
  input  logic [N*CHAR_LEN-1:0] d_frame,
  output logic                  in_ready,
  output logic [CHAR_LEN-1:0]   M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

`ifdef AXIS_TX_DBUF_EN
  localparam int NSLOT = 2;
`else
  localparam int NSLOT = 1;
`endif

  localparam logic [1:0]       SLOTS     = 2'(NSLOT);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);

  typedef enum logic {IDLE, SEND} state_e;
  typedef logic [N*CHAR_LEN-1:0] frame_t;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           occ_q, occ_d;
  logic                 in_ready_q, in_ready_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [CHAR_LEN-1:0]  tdata_q, tdata_d;
  logic                 frame_done_q, frame_done_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  frame_t               slot_q [NSLOT];
  frame_t               slot_d [NSLOT];

  logic load_acc, hs, rel;

  function automatic logic next_ptr(input logic p);
    return (NSLOT == 1) ? 1'b0 : ~p;
  endfunction

  function automatic logic [CHAR_LEN-1:0] pick(input frame_t f, input logic [CNT_W-1:0] idx);
    return f[int'(idx)*CHAR_LEN +: CHAR_LEN];
  endfunction

  // Frame FIFO bookkeeping: load and release may coincide, leaving occ unchanged.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_acc   = load & in_ready_q;
    hs         = tvalid_q & M_AXIS_TREADY;
    rel        = (state_q == SEND) & hs & (beat_q == LAST_BEAT);
    slot_d     = slot_q;
    if (load_acc) slot_d[wr_ptr_q] = d_frame;
    wr_ptr_d   = load_acc ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = rel ? next_ptr(rd_ptr_q) : rd_ptr_q;
    occ_d      = occ_q;
    if (load_acc && !rel)      occ_d = occ_q + 2'd1;
    else if (!load_acc && rel) occ_d = occ_q - 2'd1;
    in_ready_d   = (occ_d < SLOTS);
    frame_done_d = rel;
    frame_cnt_d  = rel ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    unique case (state_q)
      IDLE: begin
        if (occ_q != 2'd0) begin
          state_d  = SEND;
          beat_d   = '0;
          tvalid_d = 1'b1;
          tdata_d  = pick(slot_q[rd_ptr_q], '0);
          tlast_d  = (LAST_BEAT == '0);
        end
      end
      SEND: begin
        if (rel) begin
          beat_d = '0;
          if (occ_d != 2'd0) begin
            // Next frame may be the one written this very cycle, so read the updated slots.
            tdata_d = pick(slot_d[rd_ptr_d], '0);
            tlast_d = (LAST_BEAT == '0);
          end else begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end
        end else if (hs) begin
          beat_d  = beat_q + 1'b1;
          tdata_d = pick(slot_q[rd_ptr_q], beat_d);
          tlast_d = (beat_d == LAST_BEAT);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (ARESET) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
      in_ready_q   <= 1'b1;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      in_ready_q   <= in_ready_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // NOTE: slot storage has no reset; occ gates every read, so stale contents are never visible.
  always_ff @(posedge ACLK) begin
    slot_q <= slot_d;
  end

  assign in_ready      = in_ready_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_tx_frame.sv
// Self-checking bench for axis_tx_frame (N=4, CHAR_LEN=8): vector table plus directed multi-cycle sequences.
module tb_axis_tx_frame;

  localparam int N = 4;
  localparam int CHAR_LEN = 8;
`ifdef AXIS_TX_DBUF_EN
  localparam bit DBUF = 1'b1;
  localparam int NSLOT = 2;
`else
  localparam bit DBUF = 1'b0;
  localparam int NSLOT = 1;
`endif
  localparam logic IR1 = DBUF;  // in_ready while one frame is held

  logic        ACLK;
  logic        ARESET;
  logic        load;
  logic [31:0] d_frame;
  logic        in_ready;
  logic [7:0]  M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY;
  logic        frame_done;
  logic [15:0] frame_cnt;

  axis_tx_frame #(.N(N), .CHAR_LEN(CHAR_LEN), .CNT_W(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .load(load), .d_frame(d_frame), .in_ready(in_ready),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Stream monitor on the falling edge: logs handshakes, flags stall instability and mid-frame drops.
  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } beat_t;

  beat_t q[$];
  int    cyc = 0;
  int    proto_err = 0;
  int    done_seen = 0;
  logic  in_frame = 1'b0;
  logic  prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_rst = 1'b1;
  logic [7:0] prev_d = 8'h00;

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) begin
    if ((prev_v && !prev_r && !prev_rst &&
         (!M_AXIS_TVALID || M_AXIS_TDATA !== prev_d || M_AXIS_TLAST !== prev_l)) ||
        (in_frame && !ARESET && !M_AXIS_TVALID))
      proto_err <= proto_err + 1;
    if (ARESET) in_frame <= 1'b0;
    else if (M_AXIS_TVALID && M_AXIS_TREADY) begin
      q.push_back('{data: M_AXIS_TDATA, last: M_AXIS_TLAST, cyc: cyc});
      in_frame <= !M_AXIS_TLAST;
    end
    if (frame_done && !ARESET) done_seen <= done_seen + 1;
    prev_v   <= M_AXIS_TVALID;
    prev_r   <= M_AXIS_TREADY;
    prev_d   <= M_AXIS_TDATA;
    prev_l   <= M_AXIS_TLAST;
    prev_rst <= ARESET;
  end

  typedef struct {
    logic        rst, ld;
    logic [31:0] d;
    logic        rdy;
    logic        e_v;
    logic [7:0]  e_d;
    logic        chk_d;
    logic        e_l, e_ir, e_done;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rst, input logic ld, input logic [31:0] d, input logic rdy,
                              input logic e_v, input logic [7:0] e_d, input logic chk_d, input logic e_l,
                              input logic e_ir, input logic e_done, input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.ld = ld; v.d = d; v.rdy = rdy; v.e_v = e_v; v.e_d = e_d; v.chk_d = chk_d;
    v.e_l = e_l; v.e_ir = e_ir; v.e_done = e_done; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic load_frame(input logic [31:0] d);
    logic was;
    int   k;
    load = 1'b1;
    d_frame = d;
    was = 1'b0;
    k = 0;
    while (!was && k < 40) begin
      was = in_ready;
      step();
      k++;
    end
    load = 1'b0;
    check("load_accept", was, 1'b1);
  endtask

  task automatic collect(input int n, input int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin
      step();
      k++;
    end
    check("collect_beats", (q.size() >= n), 1'b1);
  endtask

  localparam logic [31:0] F1 = 32'h44332211;
  localparam logic [31:0] F2 = 32'h88776655;
  localparam logic [31:0] F3 = 32'hA4A3A2A1;

  initial begin
    logic [31:0] fr;
    logic [7:0]  exp_bytes[8];
    int          exp_cnt;
    int          d0;
    int          acc;
    int          lasts;
    logic        was;

    ARESET = 1'b1;
    load = 1'b0;
    d_frame = 32'h0;
    M_AXIS_TREADY = 1'b0;

    //                rst  ld  d     rdy  e_v e_d    chk e_l e_ir e_dn e_cnt
    vecs[0]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    vecs[1]  = mk(1'b0, 1'b1, F1,    1'b1, 1'b0, 8'h00, 1'b0, 1'b0, IR1,  1'b0, 16'd0);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, IR1,  1'b0, 16'd0);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, IR1,  1'b0, 16'd0);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, IR1,  1'b0, 16'd0);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1, IR1,  1'b0, 16'd0);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1);
    vecs[7]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    // Backpressure: TREADY 1,0,0,1,0,1,1 once the frame is presented
    vecs[8]  = mk(1'b0, 1'b1, F1,    1'b0, 1'b0, 8'h00, 1'b0, 1'b0, IR1,  1'b0, 16'd1);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, IR1,  1'b0, 16'd1);
    vecs[10] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, IR1,  1'b0, 16'd1);
    vecs[11] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, IR1,  1'b0, 16'd1);
    vecs[12] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, IR1,  1'b0, 16'd1);
    vecs[13] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, IR1,  1'b0, 16'd1);
    vecs[14] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, IR1,  1'b0, 16'd1);
    vecs[15] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1, IR1,  1'b0, 16'd1);
    vecs[16] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2);
    vecs[17] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);

    for (int i = 0; i < NV; i++) begin
      ARESET = vecs[i].rst;
      load = vecs[i].ld;
      d_frame = vecs[i].d;
      M_AXIS_TREADY = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_tvalid", i), M_AXIS_TVALID, vecs[i].e_v);
      if (vecs[i].chk_d) check($sformatf("vec%0d_tdata", i), M_AXIS_TDATA, vecs[i].e_d);
      check($sformatf("vec%0d_tlast", i), M_AXIS_TLAST, vecs[i].e_l);
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
      check($sformatf("vec%0d_frame_done", i), frame_done, vecs[i].e_done);
      check($sformatf("vec%0d_frame_cnt", i), frame_cnt, vecs[i].e_cnt);
    end
    load = 1'b0;
    exp_cnt = 2;

    // Overflow: fill every slot with TREADY low, then a rejected load must never surface.
    q.delete();
    M_AXIS_TREADY = 1'b0;
    load_frame(F1);
    if (DBUF) load_frame(F2);
    step();
    check("ovf_in_ready_low", in_ready, 1'b0);
    load = 1'b1;
    d_frame = 32'hDEADBEEF;
    step();
    step();
    load = 1'b0;
    M_AXIS_TREADY = 1'b1;
    collect(NSLOT * N, 40);
    for (int b = 0; b < 4; b++) begin
      fr = F1;
      exp_bytes[b] = fr[b*8 +: 8];
      fr = F2;
      exp_bytes[b+4] = fr[b*8 +: 8];
    end
    for (int i = 0; i < NSLOT * N; i++)
      if (i < q.size()) check($sformatf("ovf_beat%0d", i), q[i].data, exp_bytes[i]);
    for (int i = 0; i < 6; i++) step();
    check("ovf_beat_count", q.size(), NSLOT * N);
    exp_cnt += NSLOT;
    check("ovf_frame_cnt", frame_cnt, exp_cnt[15:0]);

    // Two frames with load held high: no gap when double-buffered, an idle gap otherwise.
    q.delete();
    d0 = done_seen;
    acc = 0;
    for (int k = 0; k < 60 && q.size() < 8; k++) begin
      load = (acc < 2);
      d_frame = (acc == 0) ? F1 : F2;
      was = load && in_ready;
      step();
      if (was) acc++;
    end
    load = 1'b0;
    check("b2b_beats", (q.size() >= 8), 1'b1);
    lasts = 0;
    for (int i = 0; i < 8; i++)
      if (i < q.size()) begin
        check($sformatf("b2b_beat%0d", i), q[i].data, exp_bytes[i]);
        lasts += int'(q[i].last);
      end
    check("b2b_tlast_count", lasts, 2);
    if (q.size() >= 8) begin
      check("b2b_last4", q[3].last, 1'b1);
      check("b2b_last8", q[7].last, 1'b1);
      check("b2b_frame_span", q[3].cyc - q[0].cyc, 3);
      check("b2b_gap", DBUF ? (q[4].cyc - q[3].cyc == 1) : (q[4].cyc - q[3].cyc >= 2), 1'b1);
    end
    for (int i = 0; i < 4; i++) step();
    exp_cnt += 2;
    check("b2b_frame_cnt", frame_cnt, exp_cnt[15:0]);
    check("b2b_done_pulses", done_seen - d0, 2);
    check("protocol_errors", proto_err, 0);

    // Reset mid-frame after 0x22 is accepted: frame aborted, counters cleared, restart from beat 0.
    q.delete();
    M_AXIS_TREADY = 1'b1;
    load_frame(F1);
    for (int k = 0; k < 20 && q.size() < 2; k++) step();
    check("rst_pre_beat", (q.size() >= 2) ? q[1].data : 8'hxx, 8'h22);
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    check("rst_tvalid", M_AXIS_TVALID, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    q.delete();
    load_frame(F3);
    collect(N, 20);
    for (int i = 0; i < N; i++)
      if (i < q.size()) begin
        fr = F3;
        check($sformatf("rst_new_beat%0d", i), q[i].data, fr[i*8 +: 8]);
        check($sformatf("rst_new_last%0d", i), q[i].last, (i == N - 1));
      end
    step();
    check("rst_new_frame_cnt", frame_cnt, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
